// File: rtl/tdm_demux4.sv
// Receiver for the 4-channel TDM serial link: collects four MSB-first WIDTH-bit slots per
// frame into a shadow register and publishes them together when a frame completes.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  localparam int unsigned FrameBits = 4 * WIDTH;
  localparam int unsigned CntW      = $clog2(FrameBits);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameBits - 1);

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [FrameBits-1:0] shadow_q, shadow_d;
  logic [FrameBits-1:0] frame_q, frame_d;
  logic                 fv_q, fv_d;
  logic                 err_q, err_d;
  logic                 locked_q, locked_d;

  // Slot A occupies the top of the shadow register, so bit k lands at FrameBits-1-k.
  logic [CntW-1:0]      bit_idx;
  logic [FrameBits-1:0] full_frame;

  assign bit_idx    = LastCnt - cnt_q;
  assign full_frame = {shadow_q[FrameBits-1:1], din};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (frame_start) begin
            shadow_d                = '0;
            shadow_d[FrameBits-1]   = din;
            cnt_d                   = CntW'(1);
            state_d                 = StRecv;
          end
        end
        StRecv: begin
          if (frame_start) begin
            // A marker anywhere but slot boundary zero aborts the partial frame.
            if (cnt_q != '0) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
            end
            shadow_d              = '0;
            shadow_d[FrameBits-1] = din;
            cnt_d                 = CntW'(1);
          end else if (cnt_q == '0) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = StHunt;
          end else begin
            shadow_d[bit_idx] = din;
            if (cnt_q == LastCnt) begin
              frame_d  = full_frame;
              fv_d     = 1'b1;
              locked_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      cnt_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign a_out       = frame_q[4*WIDTH-1 -: WIDTH];
  assign b_out       = frame_q[3*WIDTH-1 -: WIDTH];
  assign c_out       = frame_q[2*WIDTH-1 -: WIDTH];
  assign d_out       = frame_q[WIDTH-1 -: WIDTH];
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WIDTH=4): a queue-based frame model predicts decoded words,
// pulse cycles and lock state; a negedge monitor compares whatever the DUT presents.
module tb_tdm_demux4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [W-1:0] a_out, b_out, c_out, d_out;
  logic         frame_valid, sync_err, locked;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .a_out       (a_out),
    .b_out       (b_out),
    .c_out       (c_out),
    .d_out       (d_out),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] w;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] err_q[$];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference model: hunting flag plus the bits gathered so far for the current frame.
  bit          m_hunt = 1'b1;
  bit          m_bits[$];
  logic        exp_locked_nxt = 1'b0;
  logic        exp_locked = 1'b0;
  logic [15:0] cur_w = '0;

  always @(posedge clk) exp_locked <= exp_locked_nxt;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Called when an accepted bit is driven; the edge that takes it is cycle cyc+1.
  task automatic accept(input bit b, input bit fs);
    int unsigned v;
    exp_t e;
    if (m_hunt) begin
      if (fs) begin
        m_hunt = 1'b0;
        m_bits.delete();
        m_bits.push_back(b);
      end
    end else if (fs) begin
      if (m_bits.size() != 0) begin
        err_q.push_back(cyc + 1);
        exp_locked_nxt = 1'b0;
      end
      m_bits.delete();
      m_bits.push_back(b);
    end else if (m_bits.size() == 0) begin
      err_q.push_back(cyc + 1);
      exp_locked_nxt = 1'b0;
      m_hunt = 1'b1;
    end else begin
      m_bits.push_back(b);
      if (m_bits.size() == 16) begin
        v = 0;
        foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
        e.cyc = cyc + 1;
        e.w   = v[15:0];
        exp_q.push_back(e);
        exp_locked_nxt = 1'b1;
        m_bits.delete();
      end
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit fs);
    @(posedge clk);
    #1;
    din_valid   = v;
    din         = b;
    frame_start = fs;
    if (v) accept(b, fs);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    din_valid = 1'b0;
    m_hunt    = 1'b1;
    m_bits.delete();
    exp_locked_nxt = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Sends the first n bits of a frame (marker on bit 0), with random idle cycles.
  task automatic send_bits(input logic [15:0] fr, input int n, input int stall_pct);
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(0, 99)) < stall_pct)
        drive(1'b0, 1'($urandom), 1'($urandom));
      drive(1'b1, fr[15-k], k == 0);
    end
  endtask

  // Full frame with 3 idle cycles inserted after bits s1 and s2.
  task automatic send_stalled(input logic [15:0] fr, input int s1, input int s2);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, fr[15-k], k == 0);
      if (k == s1 || k == s2) repeat (3) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ec;
    if (rst) begin
      cur_w = '0;
    end else begin
      if (frame_valid && sync_err) chk(1'b0, "pulse_overlap", 32'd1, 32'd0);
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "fv_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(cyc == e.cyc, "fv_cycle", cyc, e.cyc);
          cur_w = e.w;
        end
      end
      if (sync_err) begin
        if (err_q.size() == 0) begin
          chk(1'b0, "err_spurious", 32'd1, 32'd0);
        end else begin
          ec = err_q.pop_front();
          chk(cyc == ec, "err_cycle", cyc, ec);
        end
      end
      chk({a_out, b_out, c_out, d_out} == cur_w, "outs", 32'({a_out, b_out, c_out, d_out}),
          32'(cur_w));
      chk(locked == exp_locked, "locked", 32'(locked), 32'(exp_locked));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kind;
    do_reset();
    @(negedge clk);
    chk({a_out, b_out, c_out, d_out, frame_valid, sync_err, locked} == '0, "reset",
        32'({a_out, b_out, c_out, d_out, frame_valid, sync_err, locked}), 32'd0);

    // Reset in the middle of a frame after a good frame has loaded the outputs.
    send_bits(16'h90F6, 16, 0);
    send_bits(16'h1248, 7, 0);
    do_reset();
    @(negedge clk);
    chk({a_out, b_out, c_out, d_out, frame_valid, sync_err, locked} == '0, "reset_mid",
        32'({a_out, b_out, c_out, d_out, frame_valid, sync_err, locked}), 32'd0);
    send_bits(16'h90F6, 16, 0);

    // Stalled frame, then back-to-back frames.
    send_stalled(16'h90F6, 5, 12);
    send_bits(16'h90F6, 16, 0);
    send_bits(16'h1248, 16, 0);

    // Early marker at bit 10, then a full frame from that marker.
    send_bits(16'h90F6, 16, 0);
    send_bits(16'h1248, 10, 0);
    send_bits(16'hA5C3, 16, 0);

    // Missing marker, ignored bits while hunting, then recovery.
    drive(1'b1, 1'b1, 1'b0);
    repeat (5) drive(1'b1, 1'($urandom), 1'b0);
    send_bits(16'h3E7D, 16, 0);

    for (int f = 0; f < 60; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        repeat (1 + $urandom_range(0, 3)) drive(1'b1, 1'($urandom), 1'b0);
      end else if (kind == 1) begin
        send_bits(16'($urandom), int'($urandom_range(1, 15)), 20);
      end else begin
        send_bits(16'($urandom), 16, (kind > 6) ? 30 : 0);
      end
    end

    repeat (4) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk(exp_q.size() == 0, "fv_drain", 32'(exp_q.size()), 32'd0);
    chk(err_q.size() == 0, "err_drain", 32'(err_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receiver end of the team's 4-channel time-division-multiplexed serial link. It is the opposite direction of the 4:1 select path.
- Takes one serial bit stream carrying four WIDTH-bit slots per frame (A, B, C, D, in that order, each MSB first), aligned by a frame_start marker.
- Rebuilds the four channel words and presents them together on registered outputs once each complete frame has been received.
- Reports framing errors and link lock status.

Parameters:
- WIDTH, 4, bits per slot; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- din  in  1  serial data bit
- din_valid  in  1  din is valid this cycle; when low, the block stalls and no counters advance
- frame_start  in  1  qualified by din_valid; marks din as bit 0 (MSB) of slot A
- a_out  out  WIDTH  channel A word from the last complete frame
- b_out  out  WIDTH  channel B word
- c_out  out  WIDTH  channel C word
- d_out  out  WIDTH  channel D word
- frame_valid  out  1  one-cycle pulse: a_out..d_out have just been updated
- sync_err  out  1  one-cycle pulse: framing violation detected
- locked  out  1  high once a full frame is received; low after reset or any sync_err

Behaviour:
- Reset (rst high at a clk edge):
  - a_out, b_out, c_out, d_out, frame_valid, sync_err and locked all go to 0.
  - State goes to HUNT; the bit counter is cleared; the shadow register is cleared.
  - Applies identically if asserted in the middle of a frame; the partial frame is discarded.
- Accepted bit: din_valid=1 at a rising edge. Nothing changes on cycles with din_valid=0, except that the frame_valid and sync_err pulses return to 0.
- Bit counter cnt runs 0..4*WIDTH-1 and is $clog2(4*WIDTH) bits wide. The bit at cnt=k goes to slot k/WIDTH, bit position WIDTH-1-(k mod WIDTH).
- The shadow register collects incoming bits. Outputs change only at frame completion, so a_out..d_out never show a partial frame.
- State HUNT:
  - Accepted bits with frame_start=0 are ignored, with no error raised.
  - An accepted bit with frame_start=1 is stored as cnt=0; cnt goes to 1 and state goes to RECV.
- State RECV, cnt>0, accepted bit with frame_start=0: store the bit and increment cnt.
  - If cnt=4*WIDTH-1 (last bit), the frame completes at this edge:
    - a_out..d_out are loaded from the shadow register plus this bit.
    - frame_valid=1 in the following cycle; locked goes to 1.
    - cnt wraps to 0 and state stays RECV.
- State RECV, cnt>0, accepted bit with frame_start=1 (early marker):
  - sync_err pulses; locked goes to 0; the partial frame is discarded; outputs are held.
  - The bit is taken as cnt=0 of a new frame; cnt goes to 1 and state stays RECV.
- State RECV, cnt=0 (marker expected):
  - frame_start=1: store the bit; cnt goes to 1.
  - frame_start=0 (missing marker): sync_err pulses; locked goes to 0; state goes to HUNT; the bit is discarded.
- frame_start with din_valid=0 is ignored.
- Timing:
  - Latency from the edge accepting a frame's last bit to frame_valid high is one cycle. Outputs are valid in the same cycle as frame_valid.
  - Back-to-back frames with din_valid held high give frame_valid once every 4*WIDTH cycles.
- sync_err and frame_valid never assert in the same cycle.

Test Plan (WIDTH=4):
- Reset mid-frame: assert rst after 7 bits of a frame -> all outputs 0, locked=0. The next frame is decoded correctly starting from its marker.
- Frame A=0x9, B=0x0, C=0xF, D=0x6 (bitstream 1001 0000 1111 0110), frame_start on bit 0, din_valid held high:
  - frame_valid high exactly 1 cycle after bit 15.
  - a_out=9, b_out=0, c_out=F, d_out=6; locked=1.
- Same frame with din_valid low for 3 cycles after bit 5 and again after bit 12 -> identical outputs. frame_valid arrives 6 cycles later than in the unstalled case; no sync_err.
- Two back-to-back frames (9,0,F,6) then (1,2,4,8) -> frame_valid pulses 16 cycles apart. Outputs change only at the second pulse.
- Early marker at bit 10 of the second frame -> sync_err for 1 cycle, locked=0, outputs stay (9,0,F,6). The next 16 bits from that marker decode correctly and locked=1 again.
- Missing marker at bit 0 of the next frame -> sync_err, state HUNT. Bits are ignored until frame_start, after which decoding resumes correctly.
